// File: rtl/sc_pkg.sv
// Shared stochastic-computing types: stream FSM states, counter sizing and LFSR tap masks.
package sc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sc_state_e;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Maximal-length Fibonacci tap masks; bit (t-1) set for each polynomial tap t.
    function automatic logic [31:0] lfsr_taps(input int unsigned w);
        case (w)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            24:      return 32'h00E1_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_00B8;
        endcase
    endfunction

endpackage

// File: rtl/lfsr.sv
// Free-running maximal-length Fibonacci LFSR, seeded to 1 on reset; never reaches 0.
module lfsr
    import sc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] rnd
);

    localparam logic [31:0]           TAPS_ALL = lfsr_taps(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] TAPS     = TAPS_ALL[DATA_WIDTH-1:0];

    logic feedback;

    assign feedback = ^(rnd & TAPS);

    always_ff @(posedge clk) begin
        if (rst) begin
            rnd <= DATA_WIDTH'(1);
        end else begin
            rnd <= {rnd[DATA_WIDTH-2:0], feedback};
        end
    end

endmodule

// File: rtl/sng_stream.sv
// Stochastic number generator: turns an operand into a STREAM_LEN-bit unipolar stream.
// Optional ones counter enabled by defining SNG_ONES_COUNT_EN.
module sng_stream
    import sc_pkg::*;
#(
    parameter  int unsigned WIDTH      = 8,
    parameter  int unsigned STREAM_LEN = 255,
    localparam int unsigned CW         = cnt_width(STREAM_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last
`ifdef SNG_ONES_COUNT_EN
    ,
    output logic [CW-1:0]    ones_count,
    output logic             ones_valid
`endif
);

    localparam logic [CW-1:0] LAST_IDX = CW'(STREAM_LEN - 1);

    logic [WIDTH-1:0] rnd;
    logic [WIDTH-1:0] value_reg, value_d;
    logic [CW-1:0]    cnt, cnt_d;
    sc_state_e        state, state_d;
    logic             in_ready_d, out_valid_d, out_bit_d, out_last_d;
    logic             xfer;
`ifdef SNG_ONES_COUNT_EN
    logic [CW-1:0]    ones_d;
    logic             ones_valid_d;
`endif

    lfsr #(
        .DATA_WIDTH(WIDTH)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .rnd (rnd)
    );

    assign xfer = out_valid & out_ready;

    // Next-state and next-output logic; cnt holds the number of bits already transferred.
    always_comb begin
        state_d     = state;
        value_d     = value_reg;
        cnt_d       = cnt;
        out_valid_d = out_valid;
        out_bit_d   = out_bit;
        out_last_d  = out_last;
`ifdef SNG_ONES_COUNT_EN
        ones_d       = ones_count;
        ones_valid_d = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_d     = RUN;
                    value_d     = in_value;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    out_bit_d   = (rnd <= in_value);
                    out_last_d  = (LAST_IDX == '0);
`ifdef SNG_ONES_COUNT_EN
                    ones_d      = '0;
`endif
                end
            end
            RUN: begin
                if (xfer) begin
`ifdef SNG_ONES_COUNT_EN
                    if (out_bit) ones_d = ones_count + CW'(1);
                    ones_valid_d = out_last;
`endif
                    if (out_last) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_bit_d   = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        cnt_d      = cnt + CW'(1);
                        out_bit_d  = (rnd <= value_reg);
                        out_last_d = (cnt_d == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            value_reg <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
`ifdef SNG_ONES_COUNT_EN
            ones_count <= '0;
            ones_valid <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            value_reg <= value_d;
            cnt       <= cnt_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_bit   <= out_bit_d;
            out_last  <= out_last_d;
`ifdef SNG_ONES_COUNT_EN
            ones_count <= ones_d;
            ones_valid <= ones_valid_d;
`endif
        end
    end

endmodule

// File: tb/tb_sng_stream.sv
// Directed bench for sng_stream: three instances (STREAM_LEN 255, 16 and 1) sharing clk/rst.
module tb_sng_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_bit, a_out_last;
    logic [7:0] a_in_value;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_bit, b_out_last;
    logic [7:0] b_in_value;
    logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_bit, c_out_last;
    logic [7:0] c_in_value;
`ifdef SNG_ONES_COUNT_EN
    logic [7:0] a_ones_count;
    logic [4:0] b_ones_count;
    logic [0:0] c_ones_count;
    logic       a_ones_valid, b_ones_valid, c_ones_valid;
`endif

    sng_stream #(.WIDTH(8), .STREAM_LEN(255)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_value(a_in_value),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_bit(a_out_bit), .out_last(a_out_last)
`ifdef SNG_ONES_COUNT_EN
        , .ones_count(a_ones_count), .ones_valid(a_ones_valid)
`endif
    );

    sng_stream #(.WIDTH(8), .STREAM_LEN(16)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_value(b_in_value),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bit(b_out_bit), .out_last(b_out_last)
`ifdef SNG_ONES_COUNT_EN
        , .ones_count(b_ones_count), .ones_valid(b_ones_valid)
`endif
    );

    sng_stream #(.WIDTH(8), .STREAM_LEN(1)) dut_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_value(c_in_value),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_bit(c_out_bit), .out_last(c_out_last)
`ifdef SNG_ONES_COUNT_EN
        , .ones_count(c_ones_count), .ones_valid(c_ones_valid)
`endif
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] value;
        int         exp_ones;
        bit         hold;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full 255-bit stream on dut_a with out_ready held high.
    task automatic run_a(input string name, input logic [7:0] v, input int exp_ones, input bit hold);
        int n = 0, ones = 0, last_err = 0, guard = 0;
        check({name, ".in_ready_idle"}, 32'(a_in_ready), 1);
        a_in_valid  = 1'b1;
        a_in_value  = v;
        a_out_ready = 1'b1;
        tick();
        if (!hold) a_in_valid = 1'b0;
        check({name, ".latency"}, 32'(a_out_valid), 1);
        check({name, ".in_ready_run"}, 32'(a_in_ready), 0);
        while (n < 255 && guard < 400) begin
            if (hold) a_in_value = 8'($urandom_range(0, 255));
            if (a_out_valid && a_out_ready) begin
                n++;
                ones += int'(a_out_bit);
                if (a_out_last !== (n == 255)) last_err++;
                if (a_out_last) a_in_valid = 1'b0;
            end
            tick();
            guard++;
        end
        a_in_valid = 1'b0;
        check({name, ".bits"}, 32'(n), 255);
        check({name, ".ones"}, 32'(ones), 32'(exp_ones));
        check({name, ".last_pos"}, 32'(last_err), 0);
        check({name, ".valid_after"}, 32'(a_out_valid), 0);
        check({name, ".last_after"}, 32'(a_out_last), 0);
        check({name, ".in_ready_after"}, 32'(a_in_ready), 1);
`ifdef SNG_ONES_COUNT_EN
        check({name, ".ones_valid"}, 32'(a_ones_valid), 1);
        check({name, ".ones_count"}, 32'(a_ones_count), 32'(exp_ones));
        tick();
        check({name, ".ones_valid_pulse"}, 32'(a_ones_valid), 0);
        check({name, ".ones_count_hold"}, 32'(a_ones_count), 32'(exp_ones));
`endif
    endtask

    // 16-bit stream on dut_b with random back-pressure; exp_ones < 0 skips the ones check.
    task automatic run_b(input string name, input logic [7:0] v, input int exp_ones);
        int n = 0, ones = 0, last_err = 0, stab_err = 0, guard = 0, stalls = 0;
        bit prev_stall = 1'b0;
        logic [2:0] prev = '0;
        check({name, ".in_ready_idle"}, 32'(b_in_ready), 1);
        b_in_valid  = 1'b1;
        b_in_value  = v;
        b_out_ready = 1'b0;
        tick();
        b_in_valid = 1'b0;
        while (n < 16 && guard < 400) begin
            if (prev_stall && ({b_out_valid, b_out_bit, b_out_last} !== prev)) stab_err++;
            b_out_ready = (guard == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (b_out_valid && b_out_ready) begin
                n++;
                ones += int'(b_out_bit);
                if (b_out_last !== (n == 16)) last_err++;
            end
            prev_stall = b_out_valid && !b_out_ready;
            if (prev_stall) stalls++;
            prev = {b_out_valid, b_out_bit, b_out_last};
            tick();
            guard++;
        end
        b_out_ready = 1'b1;
        check({name, ".transfers"}, 32'(n), 16);
        check({name, ".last_pos"}, 32'(last_err), 0);
        check({name, ".stall_stable"}, 32'(stab_err), 0);
        check({name, ".had_stall"}, 32'(stalls > 0), 1);
        check({name, ".valid_after"}, 32'(b_out_valid), 0);
        check({name, ".in_ready_after"}, 32'(b_in_ready), 1);
        if (exp_ones >= 0) check({name, ".ones"}, 32'(ones), 32'(exp_ones));
`ifdef SNG_ONES_COUNT_EN
        check({name, ".ones_valid"}, 32'(b_ones_valid), 1);
        check({name, ".ones_count"}, 32'(b_ones_count), 32'(ones));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int n;
        int last_seen;

        vecs[0] = '{8'd0,   0,   1'b0};
        vecs[1] = '{8'd255, 255, 1'b0};
        vecs[2] = '{8'd1,   1,   1'b0};
        vecs[3] = '{8'd128, 128, 1'b0};
        vecs[4] = '{8'd254, 254, 1'b0};
        vecs[5] = '{8'd0,   0,   1'b1};
        vecs[6] = '{8'd255, 255, 1'b1};
        vecs[7] = '{8'd37,  37,  1'b1};

        rst = 1'b1;
        a_in_valid = 1'b0; a_in_value = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_value = '0; b_out_ready = 1'b0;
        c_in_valid = 1'b0; c_in_value = '0; c_out_ready = 1'b0;
        tick();
        tick();
        check("rst.in_ready",  32'(a_in_ready), 1);
        check("rst.out_valid", 32'(a_out_valid), 0);
        check("rst.out_bit",   32'(a_out_bit), 0);
        check("rst.out_last",  32'(a_out_last), 0);
        check("rst.b_in_ready", 32'(b_in_ready), 1);
        check("rst.c_out_valid", 32'(c_out_valid), 0);
`ifdef SNG_ONES_COUNT_EN
        check("rst.ones_count", 32'(a_ones_count), 0);
        check("rst.ones_valid", 32'(a_ones_valid), 0);
`endif

        // Operand offered together with reset release: accepted on the first active edge.
        rst = 1'b0;
        run_a("v100", 8'd100, 100, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_a($sformatf("vec%0d", i), vecs[i].value, vecs[i].exp_ones, vecs[i].hold);
        end

        run_b("stall255", 8'd255, 16);
        run_b("stall0",   8'd0,   0);
        run_b("stall100", 8'd100, -1);

        // STREAM_LEN=1: the first bit is also the last; hold it through one stall.
        check("len1.in_ready", 32'(c_in_ready), 1);
        c_in_valid = 1'b1;
        c_in_value = 8'd255;
        c_out_ready = 1'b0;
        tick();
        c_in_valid = 1'b0;
        check("len1.valid", 32'(c_out_valid), 1);
        check("len1.last",  32'(c_out_last), 1);
        check("len1.bit",   32'(c_out_bit), 1);
        tick();
        check("len1.stall_valid", 32'(c_out_valid), 1);
        check("len1.stall_last",  32'(c_out_last), 1);
        c_out_ready = 1'b1;
        tick();
        check("len1.valid_after",    32'(c_out_valid), 0);
        check("len1.in_ready_after", 32'(c_in_ready), 1);
`ifdef SNG_ONES_COUNT_EN
        check("len1.ones_valid", 32'(c_ones_valid), 1);
        check("len1.ones_count", 32'(c_ones_count), 1);
`endif

        // Reset while bit 50 of a stream is on the output.
        n = 0;
        last_seen = 0;
        a_in_valid = 1'b1;
        a_in_value = 8'd255;
        a_out_ready = 1'b1;
        tick();
        a_in_valid = 1'b0;
        for (int k = 0; k < 100 && n < 49; k++) begin
            if (a_out_valid && a_out_ready) begin
                n++;
                if (a_out_last) last_seen++;
            end
            tick();
        end
        check("abort.presented_bit50", 32'(n), 49);
        check("abort.valid_before", 32'(a_out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.out_valid", 32'(a_out_valid), 0);
        check("abort.in_ready",  32'(a_in_ready), 1);
        check("abort.out_last",  32'(a_out_last), 0);
        check("abort.no_last_seen", 32'(last_seen), 0);
`ifdef SNG_ONES_COUNT_EN
        check("abort.ones_valid", 32'(a_ones_valid), 0);
`endif
        run_a("fresh", 8'd255, 255, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sng_stream.md
SNG_STREAM -- requirements
Module: sng_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and random-number width (3-20, 24 or 32).
REQ-002 SHALL have parameter STREAM_LEN, default 255, meaning bits emitted per operand (range 1 to 2^16).
REQ-003 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand offered.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port in_value  input  WIDTH  unsigned binary operand.
REQ-008 SHALL have port out_valid  output  1  out_bit valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_bit.
REQ-010 SHALL have port out_bit  output  1  stochastic stream bit.
REQ-011 SHALL have port out_last  output  1  marks the final bit of a stream.
REQ-012 SHALL have ports ones_count  output  CW, and ones_valid  output  1, only when SNG_ONES_COUNT_EN is defined; CW = clog2(STREAM_LEN+1).

Function
REQ-013 SHALL contain a free-running WIDTH-bit maximal-length LFSR, advancing every cycle, seeded to 1 by rst; its value is rnd.
REQ-014 SHALL implement FSM states IDLE and RUN; in_ready = 1 exactly in IDLE.
REQ-015 SHALL, in IDLE with in_valid=1, register in_value into value_reg, clear the bit counter and enter RUN.
REQ-016 SHALL produce each bit as registered (rnd <= value_reg), unsigned compare; rnd is never 0, so value 0 yields all zeros and 2^WIDTH-1 yields all ones.
REQ-017 SHALL present the first bit with out_valid=1 in the cycle after operand acceptance (latency 1).
REQ-018 SHALL count a bit as transferred only when out_valid and out_ready are both 1; the next bit is computed from rnd in the transfer cycle.
REQ-019 SHALL hold out_bit, out_last and out_valid stable while out_valid=1 and out_ready=0; the LFSR continues advancing.
REQ-020 SHALL assert out_last with the bit whose transfer makes the count STREAM_LEN; STREAM_LEN=1 asserts out_last on the first bit.
REQ-021 SHALL, on transfer of the out_last bit, return to IDLE, deassert out_valid and out_last, and raise in_ready next cycle; no back-to-back overlap of streams.
REQ-022 SHALL ignore in_valid while in RUN; in_value is sampled only on acceptance.

Reset
REQ-023 SHALL, the cycle after rst is sampled high, show in_ready=1, out_valid=0, out_bit=0, out_last=0, state IDLE, counter 0, LFSR=1.
REQ-024 SHALL, on rst during RUN, abandon the stream immediately without asserting out_last.
REQ-025 SHALL, with SNG_ONES_COUNT_EN, reset ones_count=0 and ones_valid=0.

Configuration
REQ-026 SHALL, with macro SNG_ONES_COUNT_EN defined, clear ones_count on operand acceptance, increment it on each transferred 1 bit, and pulse ones_valid for one cycle after the out_last transfer, holding ones_count until the next acceptance.
REQ-027 SHALL, without SNG_ONES_COUNT_EN, omit ones_count, ones_valid and the counter logic entirely; all other behaviour is identical.

Structure
REQ-028 SHALL take the FSM state enum and the counter-width function from shared package sc_pkg.
REQ-029 SHALL instantiate the existing lfsr module (DATA_WIDTH=WIDTH) as its single sub-module for rnd.

Verification
REQ-030 SHALL cover: WIDTH=8, STREAM_LEN=255, in_value=0, out_ready=1 -> 255 bits all 0, out_last on bit 255, in_ready=1 one cycle later.
REQ-031 SHALL cover: in_value=255, out_ready=1 -> 255 bits all 1; ones_count=255 with ones_valid pulse (macro on).
REQ-032 SHALL cover: operand accepted exactly 1 cycle after rst release, in_value=100, out_ready=1 -> exactly 100 ones over one full LFSR period; ones_count=100.
REQ-033 SHALL cover: out_ready toggled randomly, STREAM_LEN=16 -> exactly 16 transfers, outputs stable during stalls, out_last only on the 16th.
REQ-034 SHALL cover: rst asserted at bit 50 of a stream -> out_valid=0, in_ready=1 next cycle, no out_last, new operand then yields a full fresh stream.
REQ-035 SHALL cover: in_valid held high during RUN with changing in_value -> ignored; stream uses the accepted value only.
